// File: rtl/sdp_ram_init_if.sv
// Port bundle for sdp_ram_init: clear control, write port and read port.
// master drives requests, slave is the RAM.
interface sdp_ram_init_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BYTES  = 1
);
    logic                  clear;
    logic                  init_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_BYTES-1:0]  wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  addr_err;

    modport master (
        output clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  init_busy, rd_data, rd_valid, addr_err
    );

    modport slave (
        input  clear, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output init_busy, rd_data, rd_valid, addr_err
    );
endinterface

// File: rtl/sdp_ram_init.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable collision mode and a one-word-per-cycle clear sequence.
module sdp_ram_init #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 10,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    RD_LATENCY  = 1,
    parameter int                    WRITE_FIRST = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    localparam int                   NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH,
    localparam int                   ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic           clk,
    input logic           rst,
    sdp_ram_init_if.slave bus
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_we;
    logic                  busy;

    logic                  wr_req, wr_in, wr_ok;
    logic                  rd_ok, rd_in;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  v1_q, err_q, have_q, oor_q;
    logic [NUM_BYTES-1:0]  col_be_q;
    logic [DATA_WIDTH-1:0] col_data_q;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] data1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign busy          = (state_q == ST_CLEAR);
    assign bus.init_busy = busy;

    assign wr_req = bus.wr_en & ~busy;
    assign wr_in  = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign wr_ok  = wr_req & wr_in;
    assign rd_ok  = bus.rd_en & ~busy;
    assign rd_in  = ({1'b0, bus.rd_addr} < DEPTH_W);

    // Storage and raw read register carry no reset so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= INIT_VALUE;
        end else if (wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (bus.wr_be[b])
                    mem[bus.wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (rd_ok && rd_in)
            ram_q <= mem[bus.rd_addr];
    end

    // Side information for the read result; only refreshed on an accepted read so rd_data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            err_q      <= 1'b0;
            have_q     <= 1'b0;
            oor_q      <= 1'b0;
            col_be_q   <= '0;
            col_data_q <= '0;
        end else begin
            v1_q  <= rd_ok;
            err_q <= (rd_ok & ~rd_in) | (wr_req & ~wr_in);
            if (rd_ok) begin
                have_q     <= 1'b1;
                oor_q      <= ~rd_in;
                col_be_q   <= ((WRITE_FIRST != 0) && wr_ok && (bus.wr_addr == bus.rd_addr)) ? bus.wr_be : '0;
                col_data_q <= bus.wr_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign merged[gi*BYTE_WIDTH +: BYTE_WIDTH] = col_be_q[gi] ? col_data_q[gi*BYTE_WIDTH +: BYTE_WIDTH]
                                                                      : ram_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    assign data1        = (have_q && !oor_q) ? merged : '0;
    assign bus.addr_err = err_q;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] data2_q;
            logic                  v2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data2_q <= '0;
                    v2_q    <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q)
                        data2_q <= data1;
                end
            end

            assign bus.rd_data  = data2_q;
            assign bus.rd_valid = v2_q;
        end else begin : g_lat1
            assign bus.rd_data  = data1;
            assign bus.rd_valid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_init.sv
// Directed bench: instance A is 8-bit/latency 1/read-first, instance B is
// 32-bit/latency 2/write-first; both share clock and reset.
module tb_sdp_ram_init;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sdp_ram_init_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4), .NUM_BYTES(1)) ifa ();
    sdp_ram_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_BYTES(4)) ifb ();

    sdp_ram_init #(
        .DATA_WIDTH(8), .DEPTH(10), .BYTE_WIDTH(8), .RD_LATENCY(1),
        .WRITE_FIRST(0), .INIT_VALUE(8'hA5)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    sdp_ram_init #(
        .DATA_WIDTH(32), .DEPTH(10), .BYTE_WIDTH(8), .RD_LATENCY(2),
        .WRITE_FIRST(1), .INIT_VALUE(32'h0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (ifa.init_busy && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, 10);
        check({tag, "_b"}, ifb.init_busy, 0);
    endtask

    task automatic scan_a(input string tag, input int col_addr, input logic [7:0] col_val);
        for (int i = 0; i < 10; i++) begin
            ifa.rd_en   = 1'b1;
            ifa.rd_addr = 4'(i);
            tick();
            check($sformatf("%s_v%0d", tag, i), ifa.rd_valid, 1);
            check($sformatf("%s_d%0d", tag, i), ifa.rd_data, (i == col_addr) ? col_val : 8'hA5);
        end
        ifa.rd_en = 1'b0;
    endtask

    initial begin
        ifa.clear = 0; ifa.wr_en = 0; ifa.wr_addr = '0; ifa.wr_be = '0; ifa.wr_data = '0;
        ifa.rd_en = 0; ifa.rd_addr = '0;
        ifb.clear = 0; ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_be = '0; ifb.wr_data = '0;
        ifb.rd_en = 0; ifb.rd_addr = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy_a", ifa.init_busy, 1);
        check("rst_rdata_a", ifa.rd_data, 0);
        check("rst_valid_a", ifa.rd_valid, 0);
        check("rst_err_a", ifa.addr_err, 0);
        check("rst_busy_b", ifb.init_busy, 1);
        check("rst_rdata_b", ifb.rd_data, 0);

        rst = 1'b0;
        wait_idle("init_len");
        scan_a("init", -1, 8'hA5);
        tick();
        check("rd_idle_v", ifa.rd_valid, 0);
        check("rd_hold", ifa.rd_data, 8'hA5);

        // Read-first collision at address 5
        ifa.wr_en = 1; ifa.wr_addr = 4'd5; ifa.wr_be = 1'b1; ifa.wr_data = 8'h00;
        tick();
        ifa.wr_data = 8'h7E; ifa.rd_en = 1; ifa.rd_addr = 4'd5;
        tick();
        check("col_rf_d", ifa.rd_data, 8'h00);
        check("col_rf_v", ifa.rd_valid, 1);
        ifa.wr_en = 0;
        tick();
        check("col_after", ifa.rd_data, 8'h7E);
        ifa.rd_en = 0;

        // Out-of-range write then read
        ifa.wr_en = 1; ifa.wr_addr = 4'd12; ifa.wr_data = 8'hFF;
        tick();
        check("oor_wr_err", ifa.addr_err, 1);
        check("oor_wr_v", ifa.rd_valid, 0);
        ifa.wr_en = 0;
        tick();
        check("oor_err_pulse", ifa.addr_err, 0);
        ifa.rd_en = 1; ifa.rd_addr = 4'd15;
        tick();
        check("oor_rd_d", ifa.rd_data, 0);
        check("oor_rd_v", ifa.rd_valid, 1);
        check("oor_rd_err", ifa.addr_err, 1);
        ifa.rd_en = 0;
        tick();
        check("oor_rd_err_end", ifa.addr_err, 0);
        scan_a("post_oor", 5, 8'h7E);

        // Byte-lane merge on B, latency 2
        ifb.wr_en = 1; ifb.wr_addr = 4'd3; ifb.wr_be = 4'b1111; ifb.wr_data = 32'h11223344;
        tick();
        ifb.wr_be = 4'b0101; ifb.wr_data = 32'hAABBCCDD;
        tick();
        ifb.wr_en = 0; ifb.rd_en = 1; ifb.rd_addr = 4'd3;
        tick();
        ifb.rd_en = 0;
        check("be_early_v", ifb.rd_valid, 0);
        tick();
        check("be_v", ifb.rd_valid, 1);
        check("be_d", ifb.rd_data, 32'h11BB33DD);
        tick();
        check("be_end_v", ifb.rd_valid, 0);

        // Latency-2 streaming reads of 0,1,2
        ifb.wr_en = 1; ifb.wr_be = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            ifb.wr_addr = 4'(i);
            ifb.wr_data = 32'h10101010 * (i + 1);
            tick();
        end
        ifb.wr_en = 0;
        ifb.rd_en = 1; ifb.rd_addr = 4'd0;
        tick();
        check("st_c1_v", ifb.rd_valid, 0);
        ifb.rd_addr = 4'd1;
        tick();
        check("st_c2_v", ifb.rd_valid, 1);
        check("st_c2_d", ifb.rd_data, 32'h10101010);
        ifb.rd_addr = 4'd2;
        tick();
        check("st_c3_v", ifb.rd_valid, 1);
        check("st_c3_d", ifb.rd_data, 32'h20202020);
        ifb.rd_en = 0;
        tick();
        check("st_c4_v", ifb.rd_valid, 1);
        check("st_c4_d", ifb.rd_data, 32'h30303030);
        tick();
        check("st_c5_v", ifb.rd_valid, 0);

        // Write-first collision at address 5 on lane 0 only
        ifb.wr_en = 1; ifb.wr_addr = 4'd5; ifb.wr_be = 4'b0001; ifb.wr_data = 32'h7E7E7E7E;
        ifb.rd_en = 1; ifb.rd_addr = 4'd5;
        tick();
        ifb.wr_en = 0; ifb.rd_en = 0;
        tick();
        check("col_wf_v", ifb.rd_valid, 1);
        check("col_wf_d", ifb.rd_data, 32'h0000007E);

        // Clear request, blocked ports, reset mid-clear
        check("clr_pre", ifa.init_busy, 0);
        ifa.clear = 1;
        tick();
        ifa.clear = 0;
        check("clr_busy", ifa.init_busy, 1);
        ifa.wr_en = 1; ifa.wr_addr = 4'd2; ifa.wr_be = 1'b1; ifa.wr_data = 8'h3C;
        ifa.rd_en = 1; ifa.rd_addr = 4'd2;
        tick();
        check("clr_blk_v", ifa.rd_valid, 0);
        check("clr_blk_err", ifa.addr_err, 0);
        ifa.rd_en = 0; ifa.wr_addr = 4'd12;
        tick();
        check("clr_blk_oor", ifa.addr_err, 0);
        ifa.wr_en = 0;
        tick();
        tick();
        check("clr_still_busy", ifa.init_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", ifa.init_busy, 1);
        check("rst_mid_rdata_a", ifa.rd_data, 0);
        check("rst_mid_rdata_b", ifb.rd_data, 0);
        tick();
        rst = 1'b0;
        wait_idle("reinit_len");
        scan_a("final", -1, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_ram_init.md
Name: sdp_ram_init

Overview:
Single-clock simple dual-port RAM: one write port, one read port. It is the parametrised successor to the async FIFO storage array. It adds:
- per-byte write enables
- a selectable read latency with a read-valid strobe
- a defined read-during-write collision mode
- a sequenced memory clear, run after reset and on request, at one word per cycle

It serves as the storage for synchronous FIFOs and buffers that need realistic initialisation timing.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
DEPTH, 10, number of words; need not be a power of two.
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
WRITE_FIRST, 0, same-address collision mode: 0 = read-first (old data), 1 = write-first (new data).
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sequence.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous request to re-initialise the whole memory.
init_busy  output  1  high while the clear sequence runs; ports are blocked.
wr_en  input  1  write request.
wr_addr  input  clog2(DEPTH)  write address (minimum width 1).
wr_be  input  NUM_BYTES  per-lane write enable.
wr_data  input  DATA_WIDTH  write data.
rd_en  input  1  read request.
rd_addr  input  clog2(DEPTH)  read address.
rd_data  output  DATA_WIDTH  read data; holds its value between reads.
rd_valid  output  1  one-cycle pulse, aligned with new rd_data.
addr_err  output  1  one-cycle pulse, asserted the cycle after an out-of-range access.

Behaviour:
- Reset asserted:
  - rd_data=0, rd_valid=0, addr_err=0, init_busy=1.
  - Clear counter=0; FSM in CLEAR; all pipeline registers =0.
  - Memory array is not reset directly.
- FSM has two states, CLEAR and IDLE.
  - CLEAR: each cycle writes INIT_VALUE to mem[cnt], then cnt++.
  - After writing address DEPTH-1, FSM goes to IDLE and init_busy falls on the following edge.
  - Sequence from reset deassert to init_busy=0 takes exactly DEPTH cycles.
- IDLE with clear=1: FSM enters CLEAR on the next edge, cnt=0, init_busy=1. clear is ignored while already in CLEAR.
- Reset mid-clear: the sequence restarts from address 0 after deassert.
- While init_busy=1:
  - wr_en and rd_en are ignored: no write, no rd_valid, no addr_err.
  - Reads already in the latency pipeline still complete normally.
- Write, when wr_en=1, init_busy=0 and wr_addr<DEPTH: for each lane b with wr_be[b]=1, that lane of mem[wr_addr] takes the corresponding lane of wr_data. Lanes with wr_be=0 are unchanged. wr_be=0 entirely is a legal no-op.
- Read, when rd_en=1 and init_busy=0:
  - RD_LATENCY=1: rd_data=mem[rd_addr] and rd_valid=1 on the next edge.
  - RD_LATENCY=2: one additional output register; rd_data and rd_valid appear 2 edges after the request.
  - Back-to-back reads sustain one result per cycle.
- Out-of-range address (>=DEPTH):
  - Write is dropped.
  - Read still returns a rd_valid pulse, with rd_data=0.
  - addr_err pulses for either case, with the same latency as a 1-cycle read.
- Collision (same cycle, same address, both enabled):
  - WRITE_FIRST=0: rd_data = previous contents.
  - WRITE_FIRST=1: lanes with wr_be=1 show wr_data; other lanes show previous contents.
- Different-address simultaneous read and write: fully independent.

Test Plan:
- Reset, deassert, DEPTH=10, INIT_VALUE=8'hA5 → init_busy high exactly 10 cycles. Subsequent reads of addresses 0..9 all return 8'hA5 with rd_valid one cycle after rd_en.
- DATA_WIDTH=32: write 32'h11223344 to address 3 with wr_be=4'b1111, then 32'hAABBCCDD with wr_be=4'b0101 → read of address 3 returns 32'h11BB33DD.
- Collision at address 5 (old 8'h00, new 8'h7E) → WRITE_FIRST=0 returns 8'h00; WRITE_FIRST=1 returns 8'h7E.
- RD_LATENCY=2 streaming reads of addresses 0,1,2 on consecutive cycles → rd_valid high on cycles +2,+3,+4 with the matching data.
- Write to address 12 with DEPTH=10 → addr_err pulses once and no word changes. Read of address 15 → rd_data=0, rd_valid=1, addr_err=1.
- clear in IDLE, then wr_en pulses during CLEAR, then rst asserted after 4 clear cycles → writes ignored, clear restarts from address 0, and all words equal INIT_VALUE when init_busy falls.
